// File: rtl/ntt_bitrev_reorder.sv
// ntt_bitrev_reorder
//   Ping-pong reorder buffer. It turns bit-reversed NTT output frames back into
//   natural order. Frames of RADIX samples are written into one of two banks at
//   the bit-reversed address, then read out linearly. Each bank has a full flag
//   that gates writing and reading.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   upstream sample present
//   in_data    upstream sample (bit-reversed order)
//   in_ready   write bank not full
//   out_valid  read bank full
//   out_data   sample in natural order
//   out_last   final sample (index RADIX-1) of a frame
//   out_ready  downstream accepts out_data
module ntt_bitrev_reorder #(
    parameter int W     = 32,
    parameter int RADIX = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready
);
    localparam int L = $clog2(RADIX);

    typedef enum logic {IDLE, DRAIN} state_e;

    // Memory is intentionally not reset. Data is qualified only by the flags.
    logic [W-1:0] bank_q [2][RADIX];

    logic [1:0]   full_q, full_d;
    logic         wr_bank_q, wr_bank_d;
    logic [L-1:0] wr_cnt_q, wr_cnt_d;
    logic         rd_bank_q, rd_bank_d;
    logic [L-1:0] rd_cnt_q, rd_cnt_d;
    state_e       state_q, state_d;

    logic         wr_acc, wr_wrap, rd_xfer, rd_wrap;
    logic [1:0]   flag_set, flag_clr;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] x);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) r[i] = x[L-1-i];
        return r;
    endfunction

    assign in_ready = ~full_q[wr_bank_q];
    assign wr_acc   = in_valid & in_ready;
    assign wr_wrap  = wr_acc & (wr_cnt_q == '1);
    assign rd_xfer  = out_valid & out_ready;
    assign rd_wrap  = rd_xfer & (rd_cnt_q == '1);

    // Set and clear act on different banks. A bank being drained is full, so it
    // cannot also be the write target. Both therefore can apply in the same cycle.
    always_comb begin
        flag_set = '0;
        flag_clr = '0;
        flag_set[wr_bank_q] = wr_wrap;
        flag_clr[rd_bank_q] = rd_wrap;
        full_d    = (full_q | flag_set) & ~flag_clr;
        wr_cnt_d  = wr_acc ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_bank_d = wr_bank_q ^ wr_wrap;
        rd_cnt_d  = rd_xfer ? rd_cnt_q + 1'b1 : rd_cnt_q;
        rd_bank_d = rd_bank_q ^ rd_wrap;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) bank_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            state_q   <= IDLE;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            state_q   <= state_d;
        end
    end

    // Read FSM next state. DRAIN continues into the other bank if that bank is
    // already full when the last sample leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (full_q[rd_bank_q]) state_d = DRAIN;
            DRAIN:   if (rd_wrap && !full_q[~rd_bank_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read outputs are driven straight from the registered flag and pointers.
    always_comb begin
        out_valid = full_q[rd_bank_q];
        out_last  = full_q[rd_bank_q] & (rd_cnt_q == '1);
        out_data  = bank_q[rd_bank_q][rd_cnt_q];
    end
endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
module tb_ntt_bitrev_reorder;
    localparam int W = 32;
    localparam int RADIX = 16;
    localparam int LOG = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    ntt_bitrev_reorder #(.W(W), .RADIX(RADIX)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reverses the index bits with plain arithmetic. It walks the digits of k in base 2.
    function automatic int rev(input int k);
        int x = k;
        int r = 0;
        for (int i = 0; i < LOG; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // Reference model: collects accepted samples into frames. Each completed
    // frame is queued in natural order. The model counts frames held (max 2).
    logic [W-1:0] partial[$];
    logic [W-1:0] exp_q[$];
    int           nfull = 0;
    int           k_out = 0;
    int           acc_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    always @(negedge clk) begin
        int rel;
        int done;
        if (!rst) begin
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_out_last", {31'b0, out_last}, 0);
            chk("rst_in_ready", {31'b0, in_ready}, 1);
            partial.delete();
            exp_q.delete();
            nfull = 0;
            k_out = 0;
            prev_stall = 1'b0;
        end else begin
            rel = 0;
            done = 0;
            chk("in_ready", {31'b0, in_ready}, {31'b0, (nfull < 2)});
            chk("out_valid", {31'b0, out_valid}, {31'b0, (nfull > 0)});
            chk("set_clr_same_flag", {30'b0, dut.flag_set & dut.flag_clr}, 0);
            if (prev_stall) begin
                chk("stall_data_stable", out_data, prev_data);
                chk("stall_last_stable", {31'b0, out_last}, {31'b0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {31'b0, out_valid}, 0);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
                chk("out_last", {31'b0, out_last}, {31'b0, (k_out == RADIX - 1)});
                k_out = (k_out + 1) % RADIX;
                if (k_out == 0) rel = 1;
            end
            if (in_valid && in_ready) begin
                partial.push_back(in_data);
                acc_cnt++;
                if (partial.size() == RADIX) begin
                    for (int k = 0; k < RADIX; k++) exp_q.push_back(partial[rev(k)]);
                    partial.delete();
                    done = 1;
                end
            end
            nfull = nfull + done - rel;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Drives n consecutive values and waits for each one to be accepted.
    // All drivers run in the phase that follows a rising edge.
    task automatic send(input int base, input int n, output int stalls);
        logic a;
        int   guard;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = W'(base + i);
            guard = 0;
            do begin
                @(negedge clk);
                a = in_ready && rst;
                @(posedge clk);
                #1;
                if (!a) stalls++;
                guard++;
            end while (!a && guard < 300);
            if (!a) chk("send_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((exp_q.size() != 0 || nfull != 0) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("drain_timeout", {31'b0, (exp_q.size() == 0 && nfull == 0)}, 1);
    endtask

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp_out;
        logic         exp_last;
    } vec_t;

    vec_t tbl[RADIX];
    int   perm[RADIX] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    // Sends one frame and compares every output against the table.
    task automatic run_table(input int base);
        int st;
        for (int i = 0; i < RADIX; i++) begin
            tbl[i].din      = W'(base + i);
            tbl[i].exp_out  = W'(base + perm[i]);
            tbl[i].exp_last = (i == RADIX - 1);
        end
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < RADIX; i++) begin
                    int g;
                    in_valid = 1'b1;
                    in_data  = tbl[i].din;
                    g = 0;
                    do begin @(negedge clk); @(posedge clk); #1; g++; end
                    while (!in_ready && g < 100);
                end
                in_valid = 1'b0;
                st = 0;
            end
            begin
                for (int i = 0; i < RADIX; i++) begin
                    int g = 0;
                    do begin @(negedge clk); g++; end
                    while (!(out_valid && out_ready) && g < 200);
                    chk("tbl_out_data", out_data, tbl[i].exp_out);
                    chk("tbl_out_last", {31'b0, out_last}, {31'b0, tbl[i].exp_last});
                end
            end
        join
        drain();
    endtask

    initial begin
        int st;
        int gaps;
        int a0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Single frame, natural-order expectations from the table
        run_table(0);

        // Three back-to-back frames, including the overlap of a bank fill with a bank release
        out_ready = 1'b1;
        fork
            begin
                send(0, 48, st);
                chk("b2b_in_stalls", st, 0);
            end
            begin
                int g = 0;
                while (!out_valid && g < 100) begin @(negedge clk); g++; end
                gaps = 0;
                for (int i = 0; i < 48; i++) begin
                    if (!(out_valid && out_ready)) gaps++;
                    if (i == RADIX - 1) begin
                        chk("overlap_last", {31'b0, out_last}, 1);
                        chk("overlap_fill", {31'b0, in_valid && in_ready && in_data == 31}, 1);
                    end
                    @(negedge clk);
                end
                chk("b2b_out_gaps", gaps, 0);
            end
        join
        drain();

        // Downstream stalled while 40 samples are offered
        out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            send(0, 40, st);
            begin
                repeat (45) @(posedge clk);
                #1;
                @(negedge clk);
                chk("stall_accepts", acc_cnt - a0, 32);
                chk("stall_in_ready", {31'b0, in_ready}, 0);
                chk("stall_out_data0", out_data, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Handshake that toggles during the drain
        fork
            send(0, RADIX, st);
            for (int i = 0; i < 60; i++) begin
                out_ready = ~out_ready;
                @(posedge clk);
                #1;
            end
        join
        drain();

        // Asynchronous reset with one full frame and 7 samples of the next one held
        out_ready = 1'b0;
        send(300, RADIX + 7, st);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 0);
        chk("async_rst_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        run_table(100);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
